// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// RV32I decode stage sitting between instruction fetch and the
// register-file / ALU stage. Fetched instructions are buffered in a
// DEPTH-entry queue; the head entry is decoded combinationally and captured
// in an output register that is presented downstream under valid/ready.
// The stage adds flush, back-pressure and an illegal-opcode flag on top of
// a plain combinational RV32I decoder.
//
// Optional feature (compile-time macro DECODE_STAGE_STAT_EN):
//   adds the stat_retired / stat_illegal handshake counters and their ports.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous discard of queue and output register
//   in_valid     fetch presents in_inst / in_pc
//   in_ready     queue has room (pure function of occupancy, == !full)
//   in_inst      32-bit instruction word
//   in_pc        PC tag of the instruction (PC_W bits)
//   out_valid    decoded bundle valid
//   out_ready    downstream accepts the bundle
//   out_pc       PC tag of the decoded instruction
//   rs1/rs2/rd   register indices
//   alu_ctrl     ALU operation {funct7[5] qualifier, funct3}
//   branch_ctrl  branch condition (3'b010 = no branch)
//   w_en         register write enable (never set for rd == x0)
//   op1_sel      ALU operand 1: 1 = PC, 0 = rs1
//   imm          sign-extended immediate
//   jump_en      JAL / JALR
//   illegal      opcode outside the supported RV32I subset
//   stat_retired handshake counter        (DECODE_STAGE_STAT_EN only)
//   stat_illegal illegal handshake counter (DECODE_STAGE_STAT_EN only)
// ---------------------------------------------------------------------------
module decode_stage #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [3:0]      alu_ctrl,
  output logic [2:0]      branch_ctrl,
  output logic            w_en,
  output logic            op1_sel,
  output logic [31:0]     imm,
  output logic            jump_en,
  output logic            illegal
`ifdef DECODE_STAGE_STAT_EN
  ,
  output logic [31:0]     stat_retired,
  output logic [31:0]     stat_illegal
`endif
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] BR_NONE   = 3'b010;

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef struct packed {
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [3:0]         alu_ctrl;
    logic [2:0]         branch_ctrl;
    logic               w_en;
    logic               op1_sel;
    logic signed [31:0] imm;
    logic               jump_en;
    logic               illegal;
  } dec_t;

  localparam dec_t DEC_RST = '{branch_ctrl: BR_NONE, default: '0};

  // Immediate formats, all sign-extended from inst[31].
  function automatic logic signed [31:0] imm_i(input logic [31:0] inst);
    return $signed({{20{inst[31]}}, inst[31:20]});
  endfunction

  function automatic logic signed [31:0] imm_s(input logic [31:0] inst);
    return $signed({{20{inst[31]}}, inst[31:25], inst[11:7]});
  endfunction

  function automatic logic signed [31:0] imm_b(input logic [31:0] inst);
    return $signed({{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                    inst[11:8], 1'b0});
  endfunction

  function automatic logic signed [31:0] imm_j(input logic [31:0] inst);
    return $signed({{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                    inst[30:21], 1'b0});
  endfunction

  function automatic logic signed [31:0] imm_u(input logic [31:0] inst);
    return $signed({inst[31:12], 12'b0});
  endfunction

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t       d;
    logic [2:0] funct3;
    funct3        = inst[14:12];
    d             = DEC_RST;
    d.rs1         = inst[19:15];
    d.rs2         = inst[24:20];
    d.rd          = inst[11:7];
    d.branch_ctrl = BR_NONE;
    case (inst[6:0])
      OP_R: begin
        d.w_en     = 1'b1;
        d.alu_ctrl = {inst[30], funct3};
      end
      OP_IALU: begin
        d.w_en     = 1'b1;
        d.imm      = imm_i(inst);
        // Only the shift-right pair uses inst[30] (SRLI vs SRAI); for the
        // other I-ALU ops that bit belongs to the immediate.
        d.alu_ctrl = {(funct3 == 3'b101) ? inst[30] : 1'b0, funct3};
      end
      OP_LOAD: begin
        d.w_en = 1'b1;
        d.imm  = imm_i(inst);
      end
      OP_STORE: begin
        d.imm = imm_s(inst);
      end
      OP_BRANCH: begin
        d.imm         = imm_b(inst);
        d.branch_ctrl = funct3;
      end
      OP_JAL: begin
        d.w_en    = 1'b1;
        d.imm     = imm_j(inst);
        d.op1_sel = 1'b1;
        d.jump_en = 1'b1;
      end
      OP_JALR: begin
        d.w_en    = 1'b1;
        d.imm     = imm_i(inst);
        d.jump_en = 1'b1;
      end
      OP_LUI: begin
        d.w_en = 1'b1;
        d.imm  = imm_u(inst);
        // LUI computes x0 + imm, so the rs1 field is ignored.
        d.rs1  = 5'd0;
      end
      OP_AUIPC: begin
        d.w_en    = 1'b1;
        d.imm     = imm_u(inst);
        d.op1_sel = 1'b1;
      end
      default: begin
        d.illegal = 1'b1;
      end
    endcase
    if (d.rd == 5'd0) d.w_en = 1'b0;
    return d;
  endfunction

  logic [31:0]     inst_p0 [DEPTH];
  logic [PC_W-1:0] pc_p0   [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic            vld_p1;
  logic [PC_W-1:0] pc_p1;
  dec_t            dec_p1;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  dec_t            head_dec;
  logic [PC_W-1:0] head_pc;

  // in_ready depends only on occupancy, never on a same-cycle pop.
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full && !flush;
  assign pop      = !empty && (!vld_p1 || out_ready) && !flush;

  // ---- stage p0: instruction queue ----
  always_ff @(posedge clk) begin
    if (push) begin
      inst_p0[wr_ptr] <= in_inst;
      pc_p0[wr_ptr]   <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign head_dec = decode(inst_p0[rd_ptr]);
  assign head_pc  = pc_p0[rd_ptr];

  // ---- stage p1: decoded output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      pc_p1  <= '0;
      dec_p1 <= DEC_RST;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (pop) begin
      vld_p1 <= 1'b1;
      pc_p1  <= head_pc;
      dec_p1 <= head_dec;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid   = vld_p1;
  assign out_pc      = pc_p1;
  assign rs1         = dec_p1.rs1;
  assign rs2         = dec_p1.rs2;
  assign rd          = dec_p1.rd;
  assign alu_ctrl    = dec_p1.alu_ctrl;
  assign branch_ctrl = dec_p1.branch_ctrl;
  assign w_en        = dec_p1.w_en;
  assign op1_sel     = dec_p1.op1_sel;
  assign imm         = dec_p1.imm;
  assign jump_en     = dec_p1.jump_en;
  assign illegal     = dec_p1.illegal;

`ifdef DECODE_STAGE_STAT_EN
  logic hs_p1;
  assign hs_p1 = vld_p1 && out_ready;

  // Counters survive flush; only rst_n clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_retired <= '0;
      stat_illegal <= '0;
    end else if (hs_p1) begin
      stat_retired <= stat_retired + 32'd1;
      if (dec_p1.illegal) stat_illegal <= stat_illegal + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//
// Self-checking bench for decode_stage. Expected decode results are
// hand-derived constants per instruction; an expected bundle is queued when
// the DUT accepts an instruction and compared when the DUT hands one out.
// ---------------------------------------------------------------------------
module tb_decode_stage;

  localparam int PC_W  = 32;
  localparam int DEPTH = 4;
  localparam int NTBL  = 12;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic [2:0]  br;
    logic        w;
    logic        op1;
    logic [31:0] imm;
    logic        j;
    logic        ill;
  } ent_t;

  typedef struct packed {
    logic [31:0] pc;
    ent_t        f;
  } bundle_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [4:0]      rs1, rs2, rd;
  logic [3:0]      alu_ctrl;
  logic [2:0]      branch_ctrl;
  logic            w_en, op1_sel, jump_en, illegal;
  logic [31:0]     imm;
`ifdef DECODE_STAGE_STAT_EN
  logic [31:0]     stat_retired, stat_illegal;
`endif

  decode_stage #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rs1(rs1), .rs2(rs2), .rd(rd), .alu_ctrl(alu_ctrl),
    .branch_ctrl(branch_ctrl), .w_en(w_en), .op1_sel(op1_sel), .imm(imm),
    .jump_en(jump_en), .illegal(illegal)
`ifdef DECODE_STAGE_STAT_EN
    , .stat_retired(stat_retired), .stat_illegal(stat_illegal)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] insts   [NTBL];
  ent_t        exp_tbl [NTBL];
  bundle_t     sb [$];
  bundle_t     cur_exp;
  logic [31:0] pc_ctr;
  int          checks  = 0;
  int          passed  = 0;
  int          hs_total = 0;
  int          ill_total = 0;

  task automatic load_table();
    //            rs1    rs2    rd     alu   br      w     op1   imm            j     ill
    insts[0]  = 32'h00500093; exp_tbl[0]  = {5'd0, 5'd5,  5'd1,  4'h0, 3'b010, 1'b1, 1'b0, 32'h00000005, 1'b0, 1'b0};
    insts[1]  = 32'hFE208EE3; exp_tbl[1]  = {5'd1, 5'd2,  5'd29, 4'h0, 3'b000, 1'b0, 1'b0, 32'hFFFFFFFC, 1'b0, 1'b0};
    insts[2]  = 32'h008000EF; exp_tbl[2]  = {5'd0, 5'd8,  5'd1,  4'h0, 3'b010, 1'b1, 1'b1, 32'h00000008, 1'b1, 1'b0};
    insts[3]  = 32'h40208033; exp_tbl[3]  = {5'd1, 5'd2,  5'd0,  4'h8, 3'b010, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0};
    insts[4]  = 32'h00000013; exp_tbl[4]  = {5'd0, 5'd0,  5'd0,  4'h0, 3'b010, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0};
    insts[5]  = 32'h0000007F; exp_tbl[5]  = {5'd0, 5'd0,  5'd0,  4'h0, 3'b010, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1};
    insts[6]  = 32'h123452B7; exp_tbl[6]  = {5'd0, 5'd3,  5'd5,  4'h0, 3'b010, 1'b1, 1'b0, 32'h12345000, 1'b0, 1'b0};
    insts[7]  = 32'hFE20AC23; exp_tbl[7]  = {5'd1, 5'd2,  5'd24, 4'h0, 3'b010, 1'b0, 1'b0, 32'hFFFFFFF8, 1'b0, 1'b0};
    insts[8]  = 32'h00001197; exp_tbl[8]  = {5'd0, 5'd0,  5'd3,  4'h0, 3'b010, 1'b1, 1'b1, 32'h00001000, 1'b0, 1'b0};
    insts[9]  = 32'h00008067; exp_tbl[9]  = {5'd1, 5'd0,  5'd0,  4'h0, 3'b010, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    insts[10] = 32'h40325213; exp_tbl[10] = {5'd4, 5'd3,  5'd4,  4'hD, 3'b010, 1'b1, 1'b0, 32'h00000403, 1'b0, 1'b0};
    insts[11] = 32'hFFF12303; exp_tbl[11] = {5'd2, 5'd31, 5'd6,  4'h0, 3'b010, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
  endtask

  function automatic bundle_t observe();
    bundle_t o;
    o = {out_pc, rs1, rs2, rd, alu_ctrl, branch_ctrl, w_en, op1_sel, imm,
         jump_en, illegal};
    return o;
  endfunction

  task automatic drive(input int idx);
    in_valid = 1'b1;
    in_inst  = insts[idx];
    in_pc    = pc_ctr;
    cur_exp  = '{pc: pc_ctr, f: exp_tbl[idx]};
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_inst  = 32'h0;
  endtask

  // One clock: sample on the falling edge, advance to just past the rising edge.
  task automatic tick(output bit hs, output bit acc, output bundle_t got);
    @(negedge clk);
    hs  = out_valid && out_ready;
    acc = in_valid && in_ready && !flush;
    got = observe();
    if (hs) begin
      hs_total++;
      if (sb.size() > 0 && sb[0].f.ill) ill_total++;
    end
    if (acc) begin
      sb.push_back(cur_exp);
      pc_ctr = pc_ctr + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bundle_t want;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; in_inst = 32'h0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else passed++;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
    else passed++;
    want = '{pc: '0, f: {5'd0, 5'd0, 5'd0, 4'h0, 3'b010, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0}};
    checks++;
    if (observe() !== want) $display("FAIL reset_outputs: got %h want %h", observe(), want);
    else passed++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    bit hs, acc;
    bundle_t got, want;
    out_ready = 1'b1;
    drive(0);
    tick(hs, acc, got);
    checks++;
    if (acc !== 1'b1) $display("FAIL basic_accept: got %b want 1", acc);
    else passed++;
    idle();
    checks++;
    if (out_valid !== 1'b0) $display("FAIL basic_no_bypass: out_valid %b want 0", out_valid);
    else passed++;
    tick(hs, acc, got);
    checks++;
    if (out_valid !== 1'b1) $display("FAIL basic_latency: out_valid %b want 1", out_valid);
    else passed++;
    tick(hs, acc, got);
    checks++;
    if (!hs || sb.size() == 0) $display("FAIL basic_handshake: hs %b queued %0d want 1/1", hs, sb.size());
    else begin
      want = sb.pop_front();
      if (got !== want) $display("FAIL basic_addi: got %h want %h", got, want);
      else passed++;
    end
  endtask

  task automatic test_branch_jal();
    bit hs, acc;
    bundle_t got, want;
    int k = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (k < 2) drive(k == 0 ? 1 : 2);
      else idle();
      tick(hs, acc, got);
      if (acc) k++;
      if (hs) begin
        checks++;
        if (sb.size() == 0) $display("FAIL brjal_spurious: got %h", got);
        else begin
          want = sb.pop_front();
          if (got !== want) $display("FAIL brjal_bundle: got %h want %h", got, want);
          else passed++;
        end
      end
      if (k == 2 && sb.size() == 0) break;
    end
    idle();
    checks++;
    if (k != 2 || sb.size() != 0) $display("FAIL brjal_done: pushed %0d pending %0d want 2/0", k, sb.size());
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit hs, acc;
    bundle_t got, want;
    int seq [8] = '{6, 7, 8, 9, 10, 11, 0, 3};
    int k = 0, c = 0, miss = 0;
    out_ready = 1'b1;
    while (c < 40) begin
      if (k < 8) drive(seq[k]);
      else idle();
      tick(hs, acc, got);
      c++;
      if (k < 8) begin
        if (acc) k++;
        else miss++;
      end
      if (hs) begin
        checks++;
        if (sb.size() == 0) $display("FAIL b2b_spurious: got %h", got);
        else begin
          want = sb.pop_front();
          if (got !== want) $display("FAIL b2b_bundle: got %h want %h", got, want);
          else passed++;
        end
      end
      if (k == 8 && sb.size() == 0) break;
    end
    idle();
    checks++;
    if (miss != 0) $display("FAIL b2b_in_ready: stalled %0d cycles want 0", miss);
    else passed++;
    checks++;
    if (c != 10) $display("FAIL b2b_cycles: took %0d cycles want 10", c);
    else passed++;
  endtask

  task automatic test_stall();
    bit hs, acc;
    bundle_t got, want;
    int seq [6] = '{0, 1, 2, 6, 7, 10};
    int k = 0, held_acc = 0, outs = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 20 && k < 5; c++) begin
      drive(seq[k]);
      tick(hs, acc, got);
      if (acc) k++;
    end
    checks++;
    if (k != 5) $display("FAIL stall_fill: accepted %0d want 5", k);
    else passed++;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL stall_full: in_ready %b out_valid %b want 0/1", in_ready, out_valid);
    else passed++;
    drive(seq[5]);
    for (int c = 0; c < 3; c++) begin
      tick(hs, acc, got);
      if (acc) held_acc++;
      checks++;
      if (sb.size() == 0 || got !== sb[0]) $display("FAIL stall_hold: got %h want %h", got, sb.size() ? sb[0] : '0);
      else passed++;
    end
    checks++;
    if (held_acc != 0) $display("FAIL stall_input_held: accepted %0d want 0", held_acc);
    else passed++;
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL full_pop_in_ready: got %b want 0", in_ready);
    else passed++;
    for (int c = 0; c < 30; c++) begin
      if (k < 6) drive(seq[5]);
      else idle();
      tick(hs, acc, got);
      if (acc) k++;
      if (hs) begin
        outs++;
        checks++;
        if (sb.size() == 0) $display("FAIL stall_spurious: got %h", got);
        else begin
          want = sb.pop_front();
          if (got !== want) $display("FAIL stall_order: got %h want %h", got, want);
          else passed++;
        end
      end
      if (k == 6 && sb.size() == 0) break;
    end
    idle();
    checks++;
    if (outs != 6) $display("FAIL stall_drain: emitted %0d want 6", outs);
    else passed++;
  endtask

  task automatic test_flush();
    bit hs, acc;
    bundle_t got;
    int seen = 0;
    out_ready = 1'b1;
    drive(3);
    tick(hs, acc, got);
    drive(4);
    flush = 1'b1;
    tick(hs, acc, got);
    flush = 1'b0;
    idle();
    sb.delete();
    checks++;
    if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b want 0", out_valid);
    else passed++;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL flush_in_ready: got %b want 1", in_ready);
    else passed++;
    for (int c = 0; c < 6; c++) begin
      tick(hs, acc, got);
      if (got.pc != 32'h0 && out_valid) seen++;
      else if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) $display("FAIL flush_no_emit: emitted %0d want 0", seen);
    else passed++;
  endtask

  task automatic test_illegal();
    bit hs, acc;
    bundle_t got, want;
    int k = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (k < 1) drive(5);
      else idle();
      tick(hs, acc, got);
      if (acc) k++;
      if (hs) begin
        checks++;
        if (sb.size() == 0) $display("FAIL illegal_spurious: got %h", got);
        else begin
          want = sb.pop_front();
          if (got !== want) $display("FAIL illegal_bundle: got %h want %h", got, want);
          else passed++;
        end
      end
      if (k == 1 && sb.size() == 0) break;
    end
    idle();
    checks++;
    if (k != 1 || sb.size() != 0) $display("FAIL illegal_done: pushed %0d pending %0d", k, sb.size());
    else passed++;
`ifdef DECODE_STAGE_STAT_EN
    checks++;
    if (stat_illegal !== 32'd1) $display("FAIL stat_illegal: got %0d want 1", stat_illegal);
    else passed++;
    checks++;
    if (stat_retired !== 32'(hs_total)) $display("FAIL stat_retired: got %0d want %0d", stat_retired, hs_total);
    else passed++;
`endif
  endtask

  task automatic test_async_reset();
    bit hs, acc;
    bundle_t got, want;
    int k = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 20 && k < 5; c++) begin
      drive(k);
      tick(hs, acc, got);
      if (acc) k++;
    end
    idle();
    #2;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL areset_pre: out_valid %b in_ready %b want 1/0", out_valid, in_ready);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL areset_out_valid: got %b want 0", out_valid);
    else passed++;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL areset_in_ready: got %b want 1", in_ready);
    else passed++;
    sb.delete();
    hs_total = 0;
    ill_total = 0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      if (k < 1) drive(10);
      else idle();
      tick(hs, acc, got);
      if (acc) k++;
      if (hs) begin
        checks++;
        if (sb.size() == 0) $display("FAIL post_reset_spurious: got %h", got);
        else begin
          want = sb.pop_front();
          if (got !== want) $display("FAIL post_reset_bundle: got %h want %h", got, want);
          else passed++;
        end
      end
      if (k == 1 && sb.size() == 0) break;
    end
    idle();
    checks++;
    if (k != 1 || sb.size() != 0) $display("FAIL post_reset_done: pushed %0d pending %0d", k, sb.size());
    else passed++;
`ifdef DECODE_STAGE_STAT_EN
    checks++;
    if (stat_retired !== 32'd1 || stat_illegal !== 32'd0)
      $display("FAIL stat_after_reset: retired %0d illegal %0d want 1/0", stat_retired, stat_illegal);
    else passed++;
`endif
  endtask

  initial begin
    pc_ctr = 32'h0000_1000;
    cur_exp = '0;
    load_table();
    test_reset();
    test_basic();
    test_branch_jal();
    test_back_to_back();
    test_stall();
    test_flush();
    test_illegal();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, checks);
    $fatal(1);
  end

endmodule
